// File: rtl/mem_bank_pipe.sv
// Word memory with byte-enable writes, a self-clearing INIT sweep and an RD_LAT-deep read pipeline.
// Defining MEM_PARITY_EN adds one even-parity bit per byte and reports mismatches on rsp_err.
module mem_bank_pipe #(
   parameter int AWIDTH = 4,
   parameter int DWIDTH = 32,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [AWIDTH-1:0]   req_addr,
   input  logic [DWIDTH-1:0]   req_wdata,
   input  logic [DWIDTH/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DWIDTH-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                init_done
);
   localparam int DEPTH = 2**AWIDTH;
   localparam int NB    = DWIDTH/8;

   typedef enum logic {INIT, IDLE} state_t;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] cnt_q, cnt_d;

   logic [DWIDTH-1:0] mem_q [DEPTH];

   logic              wr_en;
   logic [AWIDTH-1:0] wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic [NB-1:0]     wr_be;
   logic              rd_fire;

   logic [RD_LAT-1:0] vld_q, vld_d;
   logic [DWIDTH-1:0] dat_q [RD_LAT];
   logic [DWIDTH-1:0] dat_d [RD_LAT];

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_ready = 1'b0;
      init_done = 1'b0;
      case (state_q)
         INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (clr) begin
               cnt_d = '0;
            end else if (cnt_q == AWIDTH'(DEPTH-1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         IDLE: begin
            init_done = 1'b1;
            req_ready = !clr;
            if (clr) begin
               state_d = INIT;
               cnt_d   = '0;
            end
         end
         default: state_d = INIT;
      endcase
   end

   assign rd_fire = req_valid && req_ready && !req_we;

   // INIT sweep owns the write port; held off while in reset so storage is untouched by rst.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = req_addr;
      wr_data = req_wdata;
      wr_be   = req_be;
      if (state_q == INIT) begin
         wr_en   = rst;
         wr_addr = cnt_q;
         wr_data = '0;
         wr_be   = '1;
      end else if (req_valid && req_ready && req_we) begin
         wr_en = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
         end
      end
   end

   always_comb begin
      vld_d[0] = rd_fire;
      dat_d[0] = mem_q[req_addr];
      for (int k = 1; k < RD_LAT; k++) begin
         vld_d[k] = vld_q[k-1];
         dat_d[k] = dat_q[k-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      dat_q <= dat_d;
   end

   assign rsp_valid = vld_q[RD_LAT-1];
   assign rsp_rdata = rsp_valid ? dat_q[RD_LAT-1] : '0;

`ifdef MEM_PARITY_EN
   function automatic logic [NB-1:0] byte_par(input logic [DWIDTH-1:0] d);
      logic [NB-1:0] p;
      for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
      return p;
   endfunction

   logic [NB-1:0]     par_q [DEPTH];
   logic [NB-1:0]     wr_par;
   logic [RD_LAT-1:0] err_q, err_d;

   assign wr_par = byte_par(wr_data);

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < NB; b++) begin
            if (wr_be[b]) par_q[wr_addr][b] <= wr_par[b];
         end
      end
   end

   // Parity is checked at the read port; the flag then rides along with the data.
   always_comb begin
      err_d[0] = |(par_q[req_addr] ^ byte_par(mem_q[req_addr]));
      for (int k = 1; k < RD_LAT; k++) err_d[k] = err_q[k-1];
   end

   always_ff @(posedge clk) begin
      err_q <= err_d;
   end

   assign rsp_err = rsp_valid & err_q[RD_LAT-1];
`else
   assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/mem_bank_pipe.md
MEM_BANK_PIPE -- requirements
Module: mem_bank_pipe

Interface
REQ-001 SHALL have parameter AWIDTH, default 4, address width; depth is 2**AWIDTH words.
REQ-002 SHALL have parameter DWIDTH, default 32, data width; legal values are multiples of 8.
REQ-003 SHALL have parameter RD_LAT, default 2, read latency in cycles; legal range is 1..4.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clr, input, 1 bit: synchronous request to clear the whole array.
REQ-007 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-008 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-009 SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port req_addr, input, AWIDTH bits: word address.
REQ-011 SHALL have port req_wdata, input, DWIDTH bits: write data.
REQ-012 SHALL have port req_be, input, DWIDTH/8 bits: byte enables for writes; ignored for reads.
REQ-013 SHALL have port rsp_valid, output, 1 bit: read data is valid this cycle.
REQ-014 SHALL have port rsp_rdata, output, DWIDTH bits: read data.
REQ-015 SHALL have port rsp_err, output, 1 bit: parity error on this response.
REQ-016 SHALL have port init_done, output, 1 bit: the array is cleared and in service.

Function
REQ-017 SHALL implement a two-state FSM with states INIT and IDLE; after reset the state is INIT.
REQ-018 In INIT, SHALL write zero (with correct parity) to one word per cycle using a counter running from 0 to 2**AWIDTH-1, then go to IDLE; INIT lasts exactly 2**AWIDTH cycles.
REQ-019 SHALL drive req_ready = 1 and init_done = 1 only in IDLE.
REQ-020 SHALL accept a request on any cycle where req_valid && req_ready is true; there is no back-pressure on responses.
REQ-021 On an accepted write, SHALL update only the bytes whose req_be bit is 1; other bytes keep their value, and no response is generated.
REQ-022 On an accepted read, SHALL assert rsp_valid for one cycle exactly RD_LAT cycles after acceptance, with rsp_rdata equal to the array contents as of the end of the acceptance cycle.
REQ-023 SHALL sustain one request per cycle; back-to-back reads return in order, one response per cycle.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-025 In cycles without a response, SHALL hold rsp_valid = 0 and rsp_rdata and rsp_err at 0.
REQ-026 clr = 1 in IDLE SHALL move the FSM to INIT on the next cycle; no request is accepted in that cycle because req_ready is already 0 combinationally.
REQ-027 clr = 1 during INIT SHALL restart the clear counter at 0.
REQ-028 Reads already in the pipeline when clr is asserted SHALL complete normally and return the pre-clear data.

Reset
REQ-029 While rst = 0, SHALL force: FSM = INIT, clear counter = 0, read pipeline empty, req_ready = 0, init_done = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-030 Reset SHALL NOT clear the array storage directly; clearing is done only by the INIT sequence.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight reads; no rsp_valid is produced after reset is released until a new read is accepted.

Configuration
REQ-032 Macro MEM_PARITY_EN defined: SHALL store one even-parity bit per byte, updated per enabled byte on writes; on a read, rsp_err = 1 when any stored parity bit mismatches its byte.
REQ-033 Macro MEM_PARITY_EN undefined: SHALL store no parity bits and drive rsp_err to constant 0; all other behaviour is unchanged.

Verification (AWIDTH=4, DWIDTH=32, RD_LAT=2)
REQ-034 Release reset -> req_ready stays 0 for 16 cycles, then goes to 1; a read of address 5 -> rsp_valid two cycles later with rsp_rdata = 0x00000000.
REQ-035 Write 0xDEADBEEF to address 3 with be = 4'b1111, then write 0x000000AA with be = 4'b0001, then read address 3 -> 0xDEADBEAA.
REQ-036 Reads of addresses 0, 1, 2, 3 on consecutive cycles, after writing 0x10 to 0x13 to them -> four consecutive rsp_valid cycles returning 0x10, 0x11, 0x12, 0x13.
REQ-037 Write 0x12345678 to address 7, then read address 7 on the next cycle -> 0x12345678.
REQ-038 Read address 3 issued, then clr asserted on the next cycle -> the read returns 0xDEADBEAA, req_ready is 0 for 16 cycles, and a later read of address 3 returns 0.
REQ-039 With MEM_PARITY_EN defined, flip one stored data bit of address 2 through a hierarchical deposit, then read address 2 -> rsp_err = 1; with MEM_PARITY_EN undefined -> rsp_err = 0.
